// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared FSM encoding and pointer-width helper for the single-clock FIFO controller
// Optional feature macro used by the controller: SYNC_FIFO_CTRL_WATERMARK_EN
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_FULL    = 2'd2
    } state_t;

    // one extra bit beyond the address distinguishes full from empty when addresses match
    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: enable-gated wrapping binary counter with async active-low reset and sync clear
// Ports:
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset
//   clear  in   synchronous return to zero, wins over en
//   en     in   advance by one
//   ptr    out  WIDTH-bit counter, wraps modulo 2**WIDTH
module fifo_ptr #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] ptr
);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            ptr <= '0;
        else if (clear)
            ptr <= '0;
        else if (en)
            ptr <= ptr + 1'b1;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: pointer and flag controller for a single-clock FIFO around a registered-read SDP RAM
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_clear          synchronous flush to empty (beats requests)
//   i_wr_en, i_rd_en producer / consumer requests
//   o_ram_we         RAM write strobe (accepted write)
//   o_wr_addr        RAM write address
//   o_rd_addr        RAM read address
//   o_rd_valid       RAM read data valid, one cycle after an accepted read
//   o_full, o_empty  status decoded from the FSM state
//   o_count          occupancy 0..DEPTH
//   o_overflow       pulse: write requested while full
//   o_underflow      pulse: read requested while empty
//   o_afull, o_aempty watermark flags, only with SYNC_FIFO_CTRL_WATERMARK_EN defined
module sync_fifo_ctrl
    import sync_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
    ,
    parameter int AFULL_LEVEL  = 2**ADDR_WIDTH - 2,
    parameter int AEMPTY_LEVEL = 2
`endif
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_wr_en,
    input  logic                  i_rd_en,
    output logic                  o_ram_we,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic                  o_rd_valid,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_overflow,
    output logic                  o_underflow
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
    ,
    output logic                  o_afull,
    output logic                  o_aempty
`endif
);

    localparam int PW = ptr_width(ADDR_WIDTH);
    localparam logic [PW-1:0] DEPTH_C = PW'(2**ADDR_WIDTH);

    state_t        state;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] cnt_nxt;
    logic          wr_acc;
    logic          rd_acc;

    assign wr_acc    = i_wr_en & ~o_full;
    assign rd_acc    = i_rd_en & ~o_empty;
    assign o_ram_we  = wr_acc & ~i_clear & i_rst_n;
    assign o_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign o_rd_addr = rd_ptr[ADDR_WIDTH-1:0];
    assign o_full    = state == ST_FULL;
    assign o_empty   = state == ST_EMPTY;
    // pointer difference modulo 2*DEPTH is the occupancy, so no separate counter is kept
    assign o_count   = wr_ptr - rd_ptr;
    assign cnt_nxt   = o_count + PW'(wr_acc) - PW'(rd_acc);

    fifo_ptr #(.WIDTH(PW)) u_wr_ptr (
        .clk(i_clk), .rst_n(i_rst_n), .clear(i_clear), .en(wr_acc), .ptr(wr_ptr)
    );

    fifo_ptr #(.WIDTH(PW)) u_rd_ptr (
        .clk(i_clk), .rst_n(i_rst_n), .clear(i_clear), .en(rd_acc), .ptr(rd_ptr)
    );

    always_ff @(posedge i_clk or negedge i_rst_n)
        if (!i_rst_n || i_clear) begin
            state       <= ST_EMPTY;
            o_rd_valid  <= 1'b0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
            o_afull     <= 1'b0;
            o_aempty    <= 1'b1;
`endif
        end else begin
            state       <= cnt_nxt == '0 ? ST_EMPTY : cnt_nxt == DEPTH_C ? ST_FULL : ST_PARTIAL;
            o_rd_valid  <= rd_acc;
            o_overflow  <= i_wr_en & o_full;
            o_underflow <= i_rd_en & o_empty;
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
            o_afull     <= int'(cnt_nxt) >= AFULL_LEVEL;
            o_aempty    <= int'(cnt_nxt) <= AEMPTY_LEVEL;
`endif
        end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: directed self-checking bench for sync_fifo_ctrl with a depth-4 FIFO
module tb_sync_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic       ram_we;
    logic [1:0] wr_addr;
    logic [1:0] rd_addr;
    logic       rd_valid;
    logic       full;
    logic       empty;
    logic [2:0] count;
    logic       ovf;
    logic       unf;
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
    logic       afull;
    logic       aempty;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sync_fifo_ctrl #(
        .ADDR_WIDTH(2)
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
        ,
        .AFULL_LEVEL(3),
        .AEMPTY_LEVEL(1)
`endif
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_clear(clr),
        .i_wr_en(wr),
        .i_rd_en(rd),
        .o_ram_we(ram_we),
        .o_wr_addr(wr_addr),
        .o_rd_addr(rd_addr),
        .o_rd_valid(rd_valid),
        .o_full(full),
        .o_empty(empty),
        .o_count(count),
        .o_overflow(ovf),
        .o_underflow(unf)
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
        ,
        .o_afull(afull),
        .o_aempty(aempty)
`endif
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic r, input logic c);
        wr  = w;
        rd  = r;
        clr = c;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_unf", unf, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_rd_addr", rd_addr, 0);
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
        check("rst_afull", afull, 0);
        check("rst_aempty", aempty, 1);
`endif
        rst_n = 1'b1;

        // fill to full, then one write too many
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 0);
            #1;
            check("fill_we", ram_we, 1);
            check("fill_wr_addr", wr_addr, i);
            cyc();
            check("fill_count", count, i + 1);
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
            check("fill_afull", afull, i >= 2);
            check("fill_aempty", aempty, i == 0);
`endif
        end
        check("fill_full", full, 1);
        check("fill_empty", empty, 0);
        #1;
        check("ovf_we", ram_we, 0);
        cyc();
        check("ovf_pulse", ovf, 1);
        check("ovf_count", count, 4);
        drive(0, 0, 0);
        cyc();
        check("ovf_clear", ovf, 0);

        // drain to empty, then one read too many
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 0);
            #1;
            check("drain_rd_addr", rd_addr, i);
            check("drain_no_we", ram_we, 0);
            cyc();
            check("drain_valid", rd_valid, 1);
            check("drain_count", count, 3 - i);
`ifdef SYNC_FIFO_CTRL_WATERMARK_EN
            check("drain_afull", afull, i == 0);
            check("drain_aempty", aempty, i >= 2);
`endif
        end
        check("drain_empty", empty, 1);
        check("drain_full", full, 0);
        cyc();
        check("unf_pulse", unf, 1);
        check("unf_no_valid", rd_valid, 0);
        drive(0, 0, 0);
        cyc();
        check("unf_clear", unf, 0);

        // two entries, then ten cycles of simultaneous traffic wrapping the addresses
        drive(1, 0, 0);
        repeat (2) cyc();
        check("sim_pre_count", count, 2);
        for (int k = 0; k < 10; k++) begin
            drive(1, 1, 0);
            #1;
            check("sim_we", ram_we, 1);
            check("sim_wr_addr", wr_addr, (2 + k) % 4);
            check("sim_rd_addr", rd_addr, k % 4);
            cyc();
            check("sim_count", count, 2);
            check("sim_full", full, 0);
            check("sim_empty", empty, 0);
            check("sim_ovf", ovf, 0);
            check("sim_unf", unf, 0);
        end

        // full with both requests: read wins, write rejected
        drive(1, 0, 0);
        repeat (2) cyc();
        check("fs_pre_full", full, 1);
        drive(1, 1, 0);
        #1;
        check("fs_we", ram_we, 0);
        cyc();
        check("fs_ovf", ovf, 1);
        check("fs_count", count, 3);
        check("fs_full", full, 0);
        check("fs_empty", empty, 0);
        check("fs_valid", rd_valid, 1);
        drive(0, 1, 0);
        repeat (3) cyc();
        check("es_pre_empty", empty, 1);

        // empty with both requests: write wins, read rejected
        drive(1, 1, 0);
        #1;
        check("es_we", ram_we, 1);
        cyc();
        check("es_unf", unf, 1);
        check("es_count", count, 1);
        check("es_valid", rd_valid, 0);
        check("es_empty", empty, 0);

        // clear beats a concurrent write
        drive(1, 0, 0);
        repeat (2) cyc();
        check("clr_pre_count", count, 3);
        drive(1, 0, 1);
        #1;
        check("clr_no_we", ram_we, 0);
        cyc();
        check("clr_count", count, 0);
        check("clr_empty", empty, 1);
        check("clr_wr_addr", wr_addr, 0);
        check("clr_rd_addr", rd_addr, 0);

        // async reset mid-burst takes effect before the next edge
        drive(1, 0, 0);
        repeat (2) cyc();
        check("ar_pre_count", count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_count", count, 0);
        check("ar_empty", empty, 1);
        check("ar_no_we", ram_we, 0);
        check("ar_wr_addr", wr_addr, 0);
        cyc();
        check("ar_hold_count", count, 0);
        drive(0, 0, 0);
        rst_n = 1'b1;
        cyc();
        check("ar_post_empty", empty, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
